ahb_slave_mem: RTL and testbench

Word-addressed AHB-style memory slave that sits directly downstream of the bus master and its slave decoder. It consumes the master's select, address, write strobe, ready and write data. It returns read data, a ready-out and an error response. Optional programmable wait states let the bus be exercised against slow targets.

---
 rtl/ahb_slave_mem.sv | 179 +++++++++++++++++
 tb/tb_ahb_slave_mem.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_slave_mem.sv
// ahb_slave_mem: word-addressed AHB-style memory slave with programmable data-phase wait states.
// Define AHB_SLAVE_MEM_ERR_EN to enable the two-cycle ERR1/ERR2 error response for bad addresses.
module ahb_slave_mem #(
  parameter logic [3:0] SLAVE_ID    = 4'b0001,
  parameter int         ADDR_W      = 6,
  parameter int         WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hreset,
  input  logic [3:0]  sel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic        hready,
  input  logic [31:0] hwdata,
  output logic [31:0] hrdata,
  output logic        hreadyout,
  output logic        hresp
);
  localparam int         DEPTH = 1 << ADDR_W;
  localparam logic [3:0] WS    = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2
`ifdef AHB_SLAVE_MEM_ERR_EN
    , S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
`endif
  } state_t;

`ifdef AHB_SLAVE_MEM_ERR_EN
  localparam state_t S_ERR_ENTRY = S_ERR1;
`else
  localparam state_t S_ERR_ENTRY = S_IDLE;
`endif

  state_t            state, next_state;
  logic [3:0]        cnt, next_cnt;
  logic [ADDR_W-1:0] idx, new_idx, rd_idx;
  logic              wr;
  logic              accept, open_st, start, err_flag;
  logic              load_rd, mem_we, ready_next;
  logic [31:0]       rd_val;
  logic [31:0]       mem [DEPTH];

  assign new_idx = haddr[ADDR_W+1:2];
  assign accept  = hready && (sel == SLAVE_ID) && hreadyout;

`ifdef AHB_SLAVE_MEM_ERR_EN
  assign err_flag = (haddr[1:0] != 2'b00) || (haddr[31:ADDR_W+2] != '0);
`else
  // Without error checking the byte offset and high address bits are simply dropped (wrap).
  logic unused_addr;
  assign unused_addr = ^{haddr[31:ADDR_W+2], haddr[1:0]};
  assign err_flag    = 1'b0;
`endif

  // Next-state, wait counter and read-path decode.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    open_st    = 1'b0;
    start      = 1'b0;
    case (state)
      S_IDLE, S_DATA: open_st = 1'b1;
      S_WAIT: begin
        next_cnt = cnt - 4'd1;
        if (cnt == 4'd1) begin
          next_state = S_DATA;
        end else begin
          next_state = S_WAIT;
        end
      end
`ifdef AHB_SLAVE_MEM_ERR_EN
      S_ERR1: next_state = S_ERR2;
      S_ERR2: open_st = 1'b1;
`endif
      default: next_state = S_IDLE;
    endcase

    // IDLE, DATA and ERR2 all accept a new transfer at their closing edge.
    if (open_st) begin
      if (accept) begin
        start = 1'b1;
        if (err_flag) begin
          next_state = S_ERR_ENTRY;
        end else if (WS != 4'd0) begin
          next_state = S_WAIT;
          next_cnt   = WS;
        end else begin
          next_state = S_DATA;
        end
      end else begin
        next_state = S_IDLE;
      end
    end else begin
      start = 1'b0;
    end

    if (start) begin
      rd_idx = new_idx;
    end else begin
      rd_idx = idx;
    end

    if (next_state == S_DATA) begin
      if (start) begin
        load_rd = !hwrite;
      end else begin
        load_rd = !wr;
      end
    end else begin
      load_rd = 1'b0;
    end

    mem_we = (state == S_DATA) && wr;
    // A write closing on this edge must be visible to a read loaded on the same edge.
    if (mem_we && (idx == rd_idx)) begin
      rd_val = hwdata;
    end else begin
      rd_val = mem[rd_idx];
    end

`ifdef AHB_SLAVE_MEM_ERR_EN
    ready_next = (next_state != S_WAIT) && (next_state != S_ERR1);
`else
    ready_next = (next_state != S_WAIT);
`endif
  end

  // State, counter, latched transfer attributes and registered outputs.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      idx       <= '0;
      wr        <= 1'b0;
      hreadyout <= 1'b1;
      hrdata    <= 32'h0;
    end else begin
      state     <= next_state;
      cnt       <= next_cnt;
      hreadyout <= ready_next;
      if (start) begin
        idx <= new_idx;
        wr  <= hwrite;
      end
      if (load_rd) begin
        hrdata <= rd_val;
      end
    end
  end

  // Storage array; cleared by reset so an abandoned write never lands.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 32'h0;
      end
    end else if (mem_we) begin
      mem[idx] <= hwdata;
    end
  end

`ifdef AHB_SLAVE_MEM_ERR_EN
  // Error response is high across both error cycles.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      hresp <= 1'b0;
    end else begin
      hresp <= (next_state == S_ERR1) || (next_state == S_ERR2);
    end
  end
`else
  assign hresp = 1'b0;
`endif

endmodule

// File: tb/tb_ahb_slave_mem.sv
// tb_ahb_slave_mem: randomized self-checking bench for ahb_slave_mem. Three instances with
// 0, 2 and 3 wait states share one bus; a word-array model per instance supplies expectations.
module tb_ahb_slave_mem;
  localparam logic [3:0] ID0   = 4'b0001;
  localparam logic [3:0] ID1   = 4'b0100;
  localparam logic [3:0] ID2   = 4'b1000;
  localparam logic [3:0] NOSEL = 4'b0010;

  logic        hclk = 1'b0;
  logic        hreset, hwrite, hready;
  logic [3:0]  sel;
  logic [31:0] haddr, hwdata;
  logic [31:0] rdata0, rdata1, rdata2;
  logic        rdy0, rdy1, rdy2, resp0, resp1, resp2;

  typedef struct {
    logic        valid;
    logic [3:0]  sel;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } xfer_t;

  xfer_t       q[$];
  logic [31:0] model [3][64];
  logic [3:0]  ids [3];
  int          wss [3];
  int          tgt, n_cmp, n_fail;

  ahb_slave_mem #(.SLAVE_ID(ID0), .ADDR_W(6), .WAIT_STATES(0)) u_ws0 (
    .hclk(hclk), .hreset(hreset), .sel(sel), .haddr(haddr), .hwrite(hwrite), .hready(hready),
    .hwdata(hwdata), .hrdata(rdata0), .hreadyout(rdy0), .hresp(resp0));
  ahb_slave_mem #(.SLAVE_ID(ID1), .ADDR_W(6), .WAIT_STATES(2)) u_ws2 (
    .hclk(hclk), .hreset(hreset), .sel(sel), .haddr(haddr), .hwrite(hwrite), .hready(hready),
    .hwdata(hwdata), .hrdata(rdata1), .hreadyout(rdy1), .hresp(resp1));
  ahb_slave_mem #(.SLAVE_ID(ID2), .ADDR_W(6), .WAIT_STATES(3)) u_ws3 (
    .hclk(hclk), .hreset(hreset), .sel(sel), .haddr(haddr), .hwrite(hwrite), .hready(hready),
    .hwdata(hwdata), .hrdata(rdata2), .hreadyout(rdy2), .hresp(resp2));

  always #5 hclk = ~hclk;

  function automatic logic get_rdy(input int k);
    if (k == 0) return rdy0;
    else if (k == 1) return rdy1;
    else return rdy2;
  endfunction

  function automatic logic get_resp(input int k);
    if (k == 0) return resp0;
    else if (k == 1) return resp1;
    else return resp2;
  endfunction

  function automatic logic [31:0] get_rdata(input int k);
    if (k == 0) return rdata0;
    else if (k == 1) return rdata1;
    else return rdata2;
  endfunction

  function automatic logic addr_err(input logic [31:0] a);
`ifdef AHB_SLAVE_MEM_ERR_EN
    return (a[1:0] != 2'b00) || (a[31:8] != 24'h0);
`else
    return (a[0] & 1'b0);
`endif
  endfunction

  task automatic push(input logic v, input logic [3:0] s, input logic [31:0] a,
                      input logic w, input logic [31:0] d);
    xfer_t x;
    x.valid = v; x.sel = s; x.addr = a; x.wr = w; x.wdata = d;
    q.push_back(x);
  endtask

  task automatic clear_model;
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 64; i++) model[k][i] = 32'h0;
  endtask

  // Plays the queued transfers to instance tgt as a pipelined master, checking every cycle.
  task automatic run_seq(input string tag);
    xfer_t       pend;
    logic        pend_v, dp_v, dp_wr, dp_err, s_rdy, s_resp, exp_rdy;
    logic [5:0]  dp_idx;
    logic [31:0] dp_wdata, dp_exp, s_data, r;
    int          dp_left, budget;
    pend_v = 1'b0; dp_v = 1'b0; dp_wr = 1'b0; dp_err = 1'b0; dp_idx = 6'd0;
    dp_wdata = 32'h0; dp_exp = 32'h0; dp_left = 0;
    budget = 8 * q.size() + 20;
    @(posedge hclk); #1;
    while (1) begin
      if (pend_v) begin
        if (pend.valid && (pend.sel == ids[tgt])) begin
          dp_v     = 1'b1;
          dp_wr    = pend.wr;
          dp_err   = addr_err(pend.addr);
          dp_idx   = pend.addr[7:2];
          dp_wdata = pend.wdata;
          dp_exp   = model[tgt][dp_idx];
          dp_left  = dp_err ? 1 : wss[tgt];
        end
        pend_v = 1'b0;
      end
      r = $urandom;
      hwdata = dp_v ? dp_wdata : r;
      s_rdy  = get_rdy(tgt);
      s_resp = get_resp(tgt);
      s_data = get_rdata(tgt);
      if (dp_v) begin
        exp_rdy = (dp_left == 0);
        n_cmp++;
        if (s_rdy !== exp_rdy) begin
          n_fail++;
          $display("FAIL %s hreadyout dut%0d idx %0d: got %b want %b", tag, tgt, dp_idx, s_rdy, exp_rdy);
        end
        n_cmp++;
        if (s_resp !== dp_err) begin
          n_fail++;
          $display("FAIL %s hresp dut%0d idx %0d: got %b want %b", tag, tgt, dp_idx, s_resp, dp_err);
        end
        if (s_rdy === 1'b1) begin
          if (!dp_wr && !dp_err) begin
            n_cmp++;
            if (s_data !== dp_exp) begin
              n_fail++;
              $display("FAIL %s hrdata dut%0d idx %0d: got %h want %h", tag, tgt, dp_idx, s_data, dp_exp);
            end
          end
          if (dp_wr && !dp_err) model[tgt][dp_idx] = dp_wdata;
          dp_v = 1'b0;
        end else if (dp_left > 0) begin
          dp_left--;
        end
      end else begin
        n_cmp++;
        if (s_rdy !== 1'b1 || s_resp !== 1'b0) begin
          n_fail++;
          $display("FAIL %s idle dut%0d: hreadyout=%b hresp=%b want 1/0", tag, tgt, s_rdy, s_resp);
        end
      end
      if (s_rdy === 1'b1) begin
        if (q.size() > 0) begin
          pend = q.pop_front();
          pend_v = 1'b1;
          hready = pend.valid; sel = pend.sel; haddr = pend.addr; hwrite = pend.wr;
        end else begin
          hready = 1'b0; sel = 4'b0000; haddr = 32'h0; hwrite = 1'b0;
        end
      end else begin
        // Stalled: wiggle the address-phase inputs, which must be ignored.
        r = $urandom;
        hready = r[0]; sel = r[1] ? ids[tgt] : 4'b0000; haddr = {24'h0, r[15:8]}; hwrite = r[2];
      end
      if (!pend_v && !dp_v && q.size() == 0) break;
      @(posedge hclk); #1;
      budget--;
      if (budget <= 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL %s timeout dut%0d: %0d transfers left, want 0", tag, tgt, q.size());
        q.delete();
        break;
      end
    end
    hready = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] v;
    hreset = 1'b1;
    repeat (2) @(posedge hclk);
    #1;
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (get_rdata(k) !== 32'h0 || get_rdy(k) !== 1'b1 || get_resp(k) !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state dut%0d: hrdata=%h hreadyout=%b hresp=%b want 0/1/0",
                 k, get_rdata(k), get_rdy(k), get_resp(k));
      end
    end
    hreset = 1'b0;
    clear_model();
    tgt = 1;
    v = $urandom | 32'h1;
    push(1'b1, ID1, 32'h20, 1'b1, v);
    push(1'b1, ID1, 32'h20, 1'b0, 32'h0);
    run_seq("rst_pre");
    @(posedge hclk); #1;
    sel = ID1; haddr = 32'h10; hwrite = 1'b1; hready = 1'b1;
    @(posedge hclk); #1;
    hready = 1'b0; hwdata = 32'hCAFE_F00D;
    n_cmp++;
    if (rdy1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_in_wait hreadyout: got %b want 0", rdy1);
    end
    #2 hreset = 1'b1;
    #1;
    n_cmp++;
    if (rdata1 !== 32'h0 || rdy1 !== 1'b1 || resp1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: hrdata=%h hreadyout=%b hresp=%b want 0/1/0", rdata1, rdy1, resp1);
    end
    @(posedge hclk); #1;
    hreset = 1'b0;
    clear_model();
    push(1'b1, ID1, 32'h10, 1'b0, 32'h0);
    push(1'b1, ID1, 32'h20, 1'b0, 32'h0);
    run_seq("rst_post");
  endtask

  task automatic test_back_to_back;
    logic [31:0] r;
    tgt = 0;
    push(1'b1, ID0, 32'h04, 1'b1, 32'hDEAD_BEEF);
    push(1'b1, ID0, 32'h04, 1'b0, 32'h0);
    for (int n = 0; n < 16; n++) begin
      r = $urandom;
      push(1'b1, ID0, {27'h0, r[4:2], 2'b00}, r[0], $urandom);
    end
    run_seq("back_to_back");
  endtask

  task automatic test_wait_states;
    tgt = 2;
    push(1'b1, ID2, 32'h08, 1'b1, 32'h1234_5678);
    push(1'b1, ID2, 32'h08, 1'b0, 32'h0);
    run_seq("wait_states");
  endtask

  task automatic test_select;
    tgt = 0;
    push(1'b1, NOSEL, 32'h0C, 1'b1, 32'hFFFF_FFFF);
    push(1'b0, ID0, 32'h0C, 1'b1, 32'hFFFF_FFFF);
    push(1'b1, ID0, 32'h0C, 1'b0, 32'h0);
    run_seq("select");
  endtask

`ifdef AHB_SLAVE_MEM_ERR_EN
  task automatic test_error;
    tgt = 1;
    push(1'b1, ID1, 32'h00, 1'b1, 32'h0BAD_F00D);
    push(1'b1, ID1, 32'h100, 1'b1, 32'h1111_2222);
    push(1'b1, ID1, 32'h00, 1'b0, 32'h0);
    push(1'b1, ID1, 32'h05, 1'b1, 32'h3333_4444);
    push(1'b1, ID1, 32'h04, 1'b0, 32'h0);
    run_seq("error");
  endtask
`else
  task automatic test_wrap;
    tgt = 0;
    push(1'b1, ID0, 32'h100, 1'b1, 32'hA5A5_A5A5);
    push(1'b1, ID0, 32'h000, 1'b0, 32'h0);
    run_seq("wrap");
  endtask
`endif

  task automatic test_random;
    logic [31:0] r, a;
    for (int k = 0; k < 3; k++) begin
      tgt = k;
      for (int n = 0; n < 40; n++) begin
        r = $urandom;
        a = $urandom;
        if (r[4:2] != 3'b000) a = {27'h0, r[7:5], 2'b00};
        if (r[10:8] == 3'b111) a[1:0] = r[18:17];
        push(r[1:0] != 2'b00, (r[15:12] == 4'h0) ? NOSEL : ids[k], a, r[16], $urandom);
      end
      run_seq("random");
    end
  endtask

  initial begin
    ids[0] = ID0; ids[1] = ID1; ids[2] = ID2;
    wss[0] = 0;   wss[1] = 2;   wss[2] = 3;
    n_cmp = 0; n_fail = 0; tgt = 0;
    hreset = 1'b1; hready = 1'b0; sel = 4'b0000; haddr = 32'h0; hwrite = 1'b0; hwdata = 32'h0;
    test_reset();
    test_back_to_back();
    test_wait_states();
    test_select();
`ifdef AHB_SLAVE_MEM_ERR_EN
    test_error();
`else
    test_wrap();
`endif
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
